// File: rtl/shiftin_rx_pkg.sv
// Shared constants for the shiftin receiver / shiftout transmitter pair.
// Holds frame/synchronizer defaults and the bit-counter width helper.
package shiftin_rx_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Counter must hold 0..WIDTH+1 so that long frames saturate distinctly from WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/shiftin_rx_sync_edge.sv
// Multi-flop synchronizer with registered rising-edge detect.
// sync_o is delayed to line up with edge_o, so data sampled with it matches the edge.
module sync_edge
    import shiftin_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   edge_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain  <= '0;
            prev   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], async_i};
            prev   <= chain[SYNC_STAGES-1];
            edge_q <= chain[SYNC_STAGES-1] & ~prev;
        end
    end

    assign sync_o = prev;
    assign edge_o = edge_q;

endmodule

// File: rtl/shiftin_rx.sv
// Serial-in receiver: MSB-first shift on sclk, parallel latch on lclk.
// Frames whose bit count differs from WIDTH are latched anyway and flagged.
module shiftin_rx
    import shiftin_rx_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ser_i,
    input  logic             sclk_i,
    input  logic             lclk_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_rdy_o,
    output logic             frame_err_o
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(WIDTH);

    logic             ser_sync;
    logic             ser_edge_unused;
    logic             sclk_edge;
    logic             sclk_sync_unused;
    logic             lclk_edge;
    logic             lclk_sync_unused;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ser_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (ser_i),
        .sync_o  (ser_sync),
        .edge_o  (ser_edge_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (sclk_i),
        .sync_o  (sclk_sync_unused),
        .edge_o  (sclk_edge)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lclk_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (lclk_i),
        .sync_o  (lclk_sync_unused),
        .edge_o  (lclk_edge)
    );

    // Shift is resolved first so a coincident latch sees the new bit and count.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        if (sclk_edge) begin
            shift_next = {shift_reg[WIDTH-2:0], ser_sync};
            if (bit_cnt != CNT_MAX) begin
                cnt_next = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            data_o      <= '0;
            data_rdy_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt     <= cnt_next;
            data_rdy_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (lclk_edge) begin
                // shift_reg is deliberately kept; the next frame shifts over it.
                data_o      <= shift_next;
                data_rdy_o  <= 1'b1;
                frame_err_o <= (cnt_next != CNT_OK);
                bit_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shiftin_rx.sv
// Directed bench for shiftin_rx: driver pushes expected frames, monitor checks each data_rdy_o.
module tb_shiftin_rx;
    import shiftin_rx_pkg::*;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int PH = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           e0;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         ser_i;
    logic         sclk_i;
    logic         lclk_i;
    logic [W-1:0] data_o;
    logic         data_rdy_o;
    logic         frame_err_o;

    shiftin_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ser_i       (ser_i),
        .sclk_i      (sclk_i),
        .lclk_i      (lclk_i),
        .data_o      (data_o),
        .data_rdy_o  (data_rdy_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    exp_t sb[$];

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        ser_i = b;
        repeat (PH) @(negedge clk_i);
        sclk_i = 1'b1;
        repeat (PH) @(negedge clk_i);
        sclk_i = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        logic [31:0] v;
        v = val;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic expect_frame(input logic [W-1:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.e0   = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic latch(input logic [W-1:0] data, input logic err);
        expect_frame(data, err);
        lclk_i = 1'b1;
        repeat (PH) @(negedge clk_i);
        lclk_i = 1'b0;
        repeat (PH) @(negedge clk_i);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_rdy"},  data_rdy_o, 0);
        check({tag, "_err"},  frame_err_o, 0);
    endtask

    // Monitor: every data_rdy_o pulse is matched against the oldest expected frame.
    initial begin
        exp_t e;
        logic rdy_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (frame_err_o && !data_rdy_o) check("err_without_rdy", frame_err_o, 0);
            if (data_rdy_o) begin
                pulses++;
                check("rdy_single_cycle", rdy_prev, 0);
                if (!rdy_prev) begin
                    check("sb_nonempty_at_rdy", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("data", data_o, e.data);
                        check("frame_err", frame_err_o, e.err);
                        check("latency", cyc - e.e0, S + 1);
                    end
                end
            end
            rdy_prev = data_rdy_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1;
        ser_i   = 1'b0;
        sclk_i  = 1'b0;
        lclk_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Nominal frame
        send_bits(32'hA5C3, 16);
        latch(16'hA5C3, 1'b0);

        // Short frame: upper nibble is left over from 0xA5C3
        send_bits(32'h0ABC, 12);
        latch(16'h3ABC, 1'b1);

        // Long frame: 20 bits, last 16 survive
        send_bits(32'h000F_BEEF, 20);
        latch(16'hBEEF, 1'b1);

        // 16th sclk rise coincident with lclk rise
        send_bits(32'h0000_4000, 15);
        ser_i = 1'b1;
        repeat (PH) @(negedge clk_i);
        expect_frame(16'h8001, 1'b0);
        sclk_i = 1'b1;
        lclk_i = 1'b1;
        repeat (PH) @(negedge clk_i);
        sclk_i = 1'b0;
        lclk_i = 1'b0;
        repeat (PH) @(negedge clk_i);

        // Latch with no preceding bits
        latch(16'h8001, 1'b1);

        // Reset mid-frame
        send_bits(32'h55, 7);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("midreset");
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);
        send_bits(32'h1234, 16);
        latch(16'h1234, 1'b0);

        // Back-to-back frames
        send_bits(32'hFFFF, 16);
        latch(16'hFFFF, 1'b0);
        send_bits(32'h0001, 16);
        latch(16'h0001, 1'b0);

        repeat (10) @(negedge clk_i);
        check("sb_drained", sb.size(), 0);
        check("rdy_pulse_count", pulses, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
